sdram_arbiter: RTL

//  Two-port arbiter/sequencer in front of sdram_ctrl (133 MHz domain). Shares the single

---
 rtl/sdram_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin arbiter/sequencer in front of sdram_ctrl (clk_133mhz).
// A write port (camera pixel writer) and a read port (display fetch) share the single
// controller command port; one transaction is in flight at a time.
// Optional watchdog abort: define SDRAM_ARB_TIMEOUT_EN to enable it (TIMEOUT_CYC cycles).
module sdram_arbiter #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_sdram_en,
    output logic              o_rw,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_datain,
    input  logic              i_ready,
    input  logic              i_dataval,
    input  logic [DATA_W-1:0] i_dataout,
    output logic              o_busy,
    output logic              o_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Port identifiers double as the o_rw encoding (0 = write, 1 = read)
    localparam logic PORT_WR = 1'b0;
    localparam logic PORT_RD = 1'b1;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              last_grant_nxt;
    logic              rd_done;
    logic              rd_done_nxt;
    logic              grant_port;
    logic              in_xfer;
    logic              wd_expire;

    logic              wr_ack_nxt;
    logic              rd_ack_nxt;
    logic [DATA_W-1:0] rd_data_nxt;
    logic              rd_valid_nxt;
    logic              sdram_en_nxt;
    logic              rw_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] datain_nxt;
    logic              busy_nxt;
    logic              err_nxt;

    assign in_xfer = (state == ACCEPT) || (state == DONE);

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = in_xfer && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: counts cycles spent in a transaction, cleared whenever idle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt <= '0;
        end else if (!in_xfer) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign unused_timeout = |TIMEOUT_CYC;
`endif

    // Winner selection: a lone requester wins, contention alternates against last grant
    always_comb begin
        grant_port = PORT_WR;
        if (i_wr_req && i_rd_req) begin
            grant_port = ~last_grant;
        end else if (i_rd_req) begin
            grant_port = PORT_RD;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        rd_done_nxt    = rd_done;
        wr_ack_nxt     = 1'b0;
        rd_ack_nxt     = 1'b0;
        rd_data_nxt    = o_rd_data;
        rd_valid_nxt   = 1'b0;
        sdram_en_nxt   = o_sdram_en;
        rw_nxt         = o_rw;
        addr_nxt       = o_addr;
        datain_nxt     = o_datain;
        err_nxt        = 1'b0;

        case (state)
            IDLE: begin
                if (i_ready && (i_wr_req || i_rd_req)) begin
                    state_nxt      = ACCEPT;
                    sdram_en_nxt   = 1'b1;
                    last_grant_nxt = grant_port;
                    rd_done_nxt    = 1'b0;
                    rw_nxt         = grant_port;
                    if (grant_port == PORT_RD) begin
                        addr_nxt   = i_rd_addr;
                        datain_nxt = '0;
                        rd_ack_nxt = 1'b1;
                    end else begin
                        addr_nxt   = i_wr_addr;
                        datain_nxt = i_wr_data;
                        wr_ack_nxt = 1'b1;
                    end
                end
            end
            ACCEPT: begin
                if (!i_ready) begin
                    sdram_en_nxt = 1'b0;
                    state_nxt    = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt    = IDLE;
                sdram_en_nxt = 1'b0;
            end
        endcase

        // Only the first data beat of a read is returned to the read port
        if (in_xfer && (o_rw == PORT_RD) && i_dataval && !rd_done) begin
            rd_data_nxt  = i_dataout;
            rd_valid_nxt = 1'b1;
            rd_done_nxt  = 1'b1;
        end

        // Watchdog abort wins over everything and suppresses any read return
        if (wd_expire) begin
            state_nxt    = IDLE;
            sdram_en_nxt = 1'b0;
            err_nxt      = 1'b1;
            rd_valid_nxt = 1'b0;
            rd_data_nxt  = o_rd_data;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            last_grant <= PORT_RD;
            rd_done    <= 1'b0;
            o_wr_ack   <= 1'b0;
            o_rd_ack   <= 1'b0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_sdram_en <= 1'b0;
            o_rw       <= 1'b0;
            o_addr     <= '0;
            o_datain   <= '0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            rd_done    <= rd_done_nxt;
            o_wr_ack   <= wr_ack_nxt;
            o_rd_ack   <= rd_ack_nxt;
            o_rd_data  <= rd_data_nxt;
            o_rd_valid <= rd_valid_nxt;
            o_sdram_en <= sdram_en_nxt;
            o_rw       <= rw_nxt;
            o_addr     <= addr_nxt;
            o_datain   <= datain_nxt;
            o_busy     <= busy_nxt;
            o_err      <= err_nxt;
        end
    end

endmodule
